// File: rtl/rv32i_types.sv
// Shared RV32I control/register encodings and the EX->MEM buffer entry layout.
// Imported by the memory-stage FIFO and its mask generator.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  // Opcode is kept as raw bits so undefined encodings can travel down the pipe and trap.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       mem_read;
    logic       mem_write;
    logic       load_regfile;
  } rv32i_control_word;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } rv32i_reg_word;

  typedef struct packed {
    logic [31:0]       pc;
    rv32i_control_word ctrl;
    rv32i_reg_word     regs;
    logic              br_en;
    logic [31:0]       alu_res;
    logic [31:0]       wdata;
    logic [3:0]        wmask;
    logic [3:0]        rmask;
    logic              trap;
  } mem_stage_entry_t;

endpackage

// File: rtl/mem_mask_gen.sv
// Byte-lane masks and trap detection for an instruction entering the memory stage.
// Purely combinational; evaluated once per enqueue and stored with the entry.
module mem_mask_gen
  import rv32i_types::*;
#(
  parameter int MISALIGN_TRAP = 1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lsb,
  output logic [3:0] wmask,
  output logic [3:0] rmask,
  output logic       trap
);

  logic [3:0] wmask_raw;
  logic [3:0] rmask_raw;
  logic       bad_op;
  logic       misaligned;

  always_comb begin
    wmask_raw  = 4'b0000;
    rmask_raw  = 4'b0000;
    bad_op     = 1'b0;
    misaligned = 1'b0;
    case (opcode)
      op_lui, op_auipc, op_jal, op_jalr, op_imm, op_reg, op_csr: ;
      op_br: begin
        case (funct3)
          beq, bne, blt, bge, bltu, bgeu: ;
          default: bad_op = 1'b1;
        endcase
      end
      op_load: begin
        case (funct3)
          lw: begin
            rmask_raw  = 4'b1111;
            misaligned = (addr_lsb != 2'b00);
          end
          lh, lhu: begin
            rmask_raw  = 4'b0011 << addr_lsb;
            misaligned = addr_lsb[0];
          end
          lb, lbu: rmask_raw = 4'b0001 << addr_lsb;
          default: bad_op = 1'b1;
        endcase
      end
      op_store: begin
        case (funct3)
          sw: begin
            wmask_raw  = 4'b1111;
            misaligned = (addr_lsb != 2'b00);
          end
          sh: begin
            wmask_raw  = 4'b0011 << addr_lsb;
            misaligned = addr_lsb[0];
          end
          sb: wmask_raw = 4'b0001 << addr_lsb;
          default: bad_op = 1'b1;
        endcase
      end
      default: bad_op = 1'b1;
    endcase
  end

  // A trapping access must never touch memory, so its lanes are suppressed.
  assign trap  = bad_op | ((MISALIGN_TRAP != 0) & misaligned);
  assign wmask = trap ? 4'b0000 : wmask_raw;
  assign rmask = trap ? 4'b0000 : rmask_raw;

endmodule

// File: rtl/mem_stage_fifo.sv
// Small circular buffer between EX and MEM; masks and trap are resolved at enqueue
// so the MEM side sees registered, ready-to-use byte lanes.
module mem_stage_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH         = 2,
  parameter int MISALIGN_TRAP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  rv32i_control_word          in_ctrl,
  input  rv32i_reg_word              in_regs,
  input  logic                       in_br_en,
  input  logic [31:0]                in_alu_res,
  input  logic [31:0]                in_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output rv32i_control_word          out_ctrl,
  output rv32i_reg_word              out_regs,
  output logic                       out_br_en,
  output logic [31:0]                out_alu_res,
  output logic [31:0]                out_wdata,
  output logic [31:0]                out_addr_aligned,
  output logic [1:0]                 out_shift,
  output logic [3:0]                 out_wmask,
  output logic [3:0]                 out_rmask,
  output logic                       out_trap,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  mem_stage_entry_t mem_q [DEPTH];
  mem_stage_entry_t mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  mem_stage_entry_t new_entry;
  mem_stage_entry_t head_entry;
  logic [3:0]       gen_wmask;
  logic [3:0]       gen_rmask;
  logic             gen_trap;
  logic             enq;
  logic             deq;

  // Explicit wrap keeps non-power-of-two depths from walking past the last slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  mem_mask_gen #(
    .MISALIGN_TRAP(MISALIGN_TRAP)
  ) u_mask_gen (
    .opcode  (in_ctrl.opcode),
    .funct3  (in_ctrl.funct3),
    .addr_lsb(in_alu_res[1:0]),
    .wmask   (gen_wmask),
    .rmask   (gen_rmask),
    .trap    (gen_trap)
  );

  always_comb begin
    new_entry         = '0;
    new_entry.pc      = in_pc;
    new_entry.ctrl    = in_ctrl;
    new_entry.regs    = in_regs;
    new_entry.br_en   = in_br_en;
    new_entry.alu_res = in_alu_res;
    new_entry.wdata   = in_wdata;
    new_entry.wmask   = gen_wmask;
    new_entry.rmask   = gen_rmask;
    new_entry.trap    = gen_trap;
  end

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CNT_W'(DEPTH)) | out_ready;
  assign enq       = in_valid & in_ready & ~flush;
  assign deq       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (deq) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (!enq && deq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Stale slot contents are hidden while empty so MEM never sees leftover data.
  always_comb begin
    head_entry = '0;
    if (out_valid) begin
      head_entry = mem_q[rd_ptr_q];
    end
  end

  assign out_pc           = head_entry.pc;
  assign out_ctrl         = head_entry.ctrl;
  assign out_regs         = head_entry.regs;
  assign out_br_en        = head_entry.br_en;
  assign out_alu_res      = head_entry.alu_res;
  assign out_wdata        = head_entry.wdata;
  assign out_addr_aligned = {head_entry.alu_res[31:2], 2'b00};
  assign out_shift        = head_entry.alu_res[1:0];
  assign out_wmask        = head_entry.wmask;
  assign out_rmask        = head_entry.rmask;
  assign out_trap         = head_entry.trap;

endmodule

// File: tb/tb_mem_stage_fifo.sv
// Scoreboard bench for mem_stage_fifo: three instances share one stimulus stream
// (DEPTH=2 trap on, DEPTH=3 trap on, DEPTH=2 trap off).
module tb_mem_stage_fifo;
  import rv32i_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, in_valid, out_ready, in_br_en;
  logic [31:0]       in_pc, in_alu_res, in_wdata;
  rv32i_control_word in_ctrl;
  rv32i_reg_word     in_regs;

  logic a_in_ready, a_out_valid, a_out_br_en, a_out_trap;
  logic [31:0] a_out_pc, a_out_alu_res, a_out_wdata, a_out_addr_aligned;
  rv32i_control_word a_out_ctrl;
  rv32i_reg_word a_out_regs;
  logic [1:0] a_out_shift, a_count;
  logic [3:0] a_out_wmask, a_out_rmask;

  logic b_in_ready, b_out_valid, b_out_br_en, b_out_trap;
  logic [31:0] b_out_pc, b_out_alu_res, b_out_wdata, b_out_addr_aligned;
  rv32i_control_word b_out_ctrl;
  rv32i_reg_word b_out_regs;
  logic [1:0] b_out_shift, b_count;
  logic [3:0] b_out_wmask, b_out_rmask;

  logic c_in_ready, c_out_valid, c_out_br_en, c_out_trap;
  logic [31:0] c_out_pc, c_out_alu_res, c_out_wdata, c_out_addr_aligned;
  rv32i_control_word c_out_ctrl;
  rv32i_reg_word c_out_regs;
  logic [1:0] c_out_shift, c_count;
  logic [3:0] c_out_wmask, c_out_rmask;

  mem_stage_fifo #(.DEPTH(2), .MISALIGN_TRAP(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_ctrl(in_ctrl), .in_regs(in_regs), .in_br_en(in_br_en),
    .in_alu_res(in_alu_res), .in_wdata(in_wdata), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_ctrl(a_out_ctrl), .out_regs(a_out_regs), .out_br_en(a_out_br_en),
    .out_alu_res(a_out_alu_res), .out_wdata(a_out_wdata), .out_addr_aligned(a_out_addr_aligned),
    .out_shift(a_out_shift), .out_wmask(a_out_wmask), .out_rmask(a_out_rmask),
    .out_trap(a_out_trap), .count(a_count));

  mem_stage_fifo #(.DEPTH(3), .MISALIGN_TRAP(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_ctrl(in_ctrl), .in_regs(in_regs), .in_br_en(in_br_en),
    .in_alu_res(in_alu_res), .in_wdata(in_wdata), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_ctrl(b_out_ctrl), .out_regs(b_out_regs), .out_br_en(b_out_br_en),
    .out_alu_res(b_out_alu_res), .out_wdata(b_out_wdata), .out_addr_aligned(b_out_addr_aligned),
    .out_shift(b_out_shift), .out_wmask(b_out_wmask), .out_rmask(b_out_rmask),
    .out_trap(b_out_trap), .count(b_count));

  mem_stage_fifo #(.DEPTH(2), .MISALIGN_TRAP(0)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_pc(in_pc), .in_ctrl(in_ctrl), .in_regs(in_regs), .in_br_en(in_br_en),
    .in_alu_res(in_alu_res), .in_wdata(in_wdata), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_pc(c_out_pc), .out_ctrl(c_out_ctrl), .out_regs(c_out_regs), .out_br_en(c_out_br_en),
    .out_alu_res(c_out_alu_res), .out_wdata(c_out_wdata), .out_addr_aligned(c_out_addr_aligned),
    .out_shift(c_out_shift), .out_wmask(c_out_wmask), .out_rmask(c_out_rmask),
    .out_trap(c_out_trap), .count(c_count));

  typedef struct packed {
    logic [31:0]       pc;
    rv32i_control_word ctrl;
    logic [31:0]       alu;
    logic [31:0]       wdata;
    rv32i_reg_word     regs;
    logic              br;
  } exp_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mcount   = 0;

  task automatic set_entry(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] alu);
    in_ctrl              = '0;
    in_ctrl.opcode       = op;
    in_ctrl.funct3       = f3;
    in_ctrl.funct7       = pc[8:2];
    in_ctrl.mem_read     = (op == op_load);
    in_ctrl.mem_write    = (op == op_store);
    in_ctrl.load_regfile = (op != op_store);
    in_regs              = '{rs1: pc[6:2], rs2: pc[11:7], rd: pc[16:12]};
    in_pc                = pc;
    in_alu_res           = alu;
    in_wdata             = ~pc ^ {alu[15:0], alu[31:16]};
    in_br_en             = pc[3];
  endtask

  function automatic exp_t cur_exp();
    return '{pc: in_pc, ctrl: in_ctrl, alu: in_alu_res, wdata: in_wdata, regs: in_regs, br: in_br_en};
  endfunction

  // Reference for {trap, wmask, rmask}, written from access size and alignment.
  function automatic logic [8:0] exp_mask(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [1:0] a, input bit mt);
    bit ld, st, bad;
    int nbytes;
    logic [3:0] m;
    ld = 0; st = 0; bad = 0; nbytes = 0;
    if (op == op_load) begin
      ld = 1;
      if (f3 == 3'd0 || f3 == 3'd4) nbytes = 1;
      else if (f3 == 3'd1 || f3 == 3'd5) nbytes = 2;
      else if (f3 == 3'd2) nbytes = 4;
      else bad = 1;
    end else if (op == op_store) begin
      st = 1;
      if (f3 <= 3'd2) nbytes = 1 << f3;
      else bad = 1;
    end else if (op == op_br) begin
      bad = (f3 == 3'd2 || f3 == 3'd3);
    end else if (!(op inside {op_lui, op_auipc, op_jal, op_jalr, op_imm, op_reg, op_csr})) begin
      bad = 1;
    end
    if (mt && nbytes > 1 && (int'(a) % nbytes) != 0) bad = 1;
    if (nbytes == 4) m = 4'hF;
    else if (nbytes == 2) m = 4'b0011 << a;
    else if (nbytes == 1) m = 4'b0001 << a;
    else m = 4'h0;
    if (bad) m = 4'h0;
    return {bad, st ? m : 4'h0, ld ? m : 4'h0};
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_entry(op_reg, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    mcount = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_entry(op_reg, 3'd0, 32'h0, 32'h0);
    #1 rst = 1'b1;
    #2;
    n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", a_count); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    n_checks++; if ({a_out_pc, a_out_wmask, a_out_trap} !== 37'd0) begin n_fail++; $display("[TB] FAIL reset_outputs: got %h expected 0", {a_out_pc, a_out_wmask, a_out_trap}); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({a_count, a_out_valid, a_in_ready} !== 4'b0001) begin n_fail++; $display("[TB] FAIL post_reset_state: got %b expected 0001", {a_count, a_out_valid, a_in_ready}); end
  endtask

  task automatic test_sb_align();
    do_reset();
    set_entry(op_store, sb, 32'h0000_0100, 32'h0000_1003);
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_no_comb_path: got %b expected 0", a_out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_out_valid: got %b expected 1", a_out_valid); end
    n_checks++; if (a_out_wmask !== 4'b1000) begin n_fail++; $display("[TB] FAIL sb_wmask: got %b expected 1000", a_out_wmask); end
    n_checks++; if (a_out_addr_aligned !== 32'h1000) begin n_fail++; $display("[TB] FAIL sb_addr_aligned: got %h expected 00001000", a_out_addr_aligned); end
    n_checks++; if (a_out_shift !== 2'd3) begin n_fail++; $display("[TB] FAIL sb_shift: got %0d expected 3", a_out_shift); end
    n_checks++; if (a_count !== 2'd1) begin n_fail++; $display("[TB] FAIL sb_count: got %0d expected 1", a_count); end
    n_checks++; if ({a_out_trap, a_out_rmask, a_out_pc} !== {1'b0, 4'b0000, 32'h100}) begin n_fail++; $display("[TB] FAIL sb_misc: got %h expected 000000100", {a_out_trap, a_out_rmask, a_out_pc}); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_rdy;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_entry(op_reg, 3'd0, 32'h200 + 32'(4 * i), 32'(i * 17 + 5));
      in_valid = 1'b1;
      @(negedge clk);
      exp_rdy = (mcount < 2) || out_ready;
      n_checks++; if (a_in_ready !== exp_rdy) begin n_fail++; $display("[TB] FAIL fill_in_ready[%0d]: got %b expected %b", i, a_in_ready, exp_rdy); end
      if (exp_rdy) begin sb_q.push_back(cur_exp()); mcount++; end
      @(posedge clk); #1;
    end
    n_checks++; if (a_count !== 2'd2) begin n_fail++; $display("[TB] FAIL fill_count: got %0d expected 2", a_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_entry(op_imm, 3'd0, 32'h300 + 32'(4 * i), 32'hABC0 + 32'(i));
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++; if ({a_in_ready, a_out_valid} !== 2'b11) begin n_fail++; $display("[TB] FAIL b2b_handshake[%0d]: got %b expected 11", i, {a_in_ready, a_out_valid}); end
      e = sb_q.pop_front();
      n_checks++; if ({a_out_pc, a_out_ctrl, a_out_alu_res, a_out_wdata, a_out_regs, a_out_br_en} !== e) begin n_fail++; $display("[TB] FAIL b2b_order[%0d]: got pc %h expected pc %h", i, a_out_pc, e.pc); end
      sb_q.push_back(cur_exp());
      @(posedge clk); #1;
      n_checks++; if (a_count !== 2'd2) begin n_fail++; $display("[TB] FAIL b2b_count[%0d]: got %0d expected 2", i, a_count); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++; if (a_out_valid !== 1'b1 || a_out_pc !== e.pc || a_out_wdata !== e.wdata) begin n_fail++; $display("[TB] FAIL drain[%0d]: got valid %b pc %h expected valid 1 pc %h", k, a_out_valid, a_out_pc, e.pc); end
      @(posedge clk); #1;
    end
    n_checks++; if ({a_count, a_out_valid, a_out_pc} !== 35'd0) begin n_fail++; $display("[TB] FAIL drain_empty: got count %0d valid %b pc %h expected 0 0 0", a_count, a_out_valid, a_out_pc); end
    out_ready = 1'b0;
  endtask

  task automatic test_misalign();
    logic [8:0] ea, ec;
    vec_t vecs [14] = '{
      '{op_store, 3'd1, 32'h11}, '{op_load, 3'd1, 32'h12}, '{op_load, 3'd4, 32'h13},
      '{op_store, 3'd2, 32'h20}, '{op_store, 3'd2, 32'h21}, '{op_load, 3'd5, 32'h23},
      '{op_load, 3'd3, 32'h30}, '{op_store, 3'd4, 32'h30}, '{op_br, 3'd2, 32'h40},
      '{op_br, 3'd0, 32'h41}, '{7'h7F, 3'd0, 32'h50}, '{op_reg, 3'd3, 32'h51},
      '{op_load, 3'd0, 32'h01}, '{op_store, 3'd0, 32'h02}};
    do_reset();
    set_entry(op_load, lw, 32'h0000_0500, 32'h0000_2002);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if ({a_out_trap, a_out_rmask} !== 5'b1_0000) begin n_fail++; $display("[TB] FAIL lw_misaligned_trap_on: got trap %b rmask %b expected 1 0000", a_out_trap, a_out_rmask); end
    n_checks++; if ({c_out_trap, c_out_rmask} !== 5'b0_1111) begin n_fail++; $display("[TB] FAIL lw_misaligned_trap_off: got trap %b rmask %b expected 0 1111", c_out_trap, c_out_rmask); end
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_entry(vecs[i].op, vecs[i].f3, 32'h600 + 32'(4 * i), vecs[i].alu);
      in_valid = 1'b1;
      ea = exp_mask(vecs[i].op, vecs[i].f3, vecs[i].alu[1:0], 1'b1);
      ec = exp_mask(vecs[i].op, vecs[i].f3, vecs[i].alu[1:0], 1'b0);
      @(posedge clk); #1;
      n_checks++; if ({a_out_trap, a_out_wmask, a_out_rmask} !== ea) begin n_fail++; $display("[TB] FAIL mask_trap_on[%0d]: got %b expected %b", i, {a_out_trap, a_out_wmask, a_out_rmask}, ea); end
      n_checks++; if ({c_out_trap, c_out_wmask, c_out_rmask} !== ec) begin n_fail++; $display("[TB] FAIL mask_trap_off[%0d]: got %b expected %b", i, {c_out_trap, c_out_wmask, c_out_rmask}, ec); end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_entry(op_store, sb, 32'h700 + 32'(4 * i), 32'hFFFF_0003);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (a_count !== 2'd2) begin n_fail++; $display("[TB] FAIL flush_prefill: got %0d expected 2", a_count); end
    set_entry(op_load, lw, 32'h740, 32'h0000_0010);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++; if ({a_count, a_out_valid, a_in_ready} !== 4'b0001) begin n_fail++; $display("[TB] FAIL flush_state: got %b expected 0001", {a_count, a_out_valid, a_in_ready}); end
    n_checks++; if ({a_out_pc, a_out_ctrl, a_out_regs, a_out_br_en, a_out_alu_res, a_out_wdata, a_out_addr_aligned,
                     a_out_shift, a_out_wmask, a_out_rmask, a_out_trap} !== '0) begin
      n_fail++; $display("[TB] FAIL flush_outputs_zero: got pc %h alu %h wmask %b expected all zero", a_out_pc, a_out_alu_res, a_out_wmask);
    end
    set_entry(op_reg, 3'd0, 32'h7A0, 32'h1234);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if ({a_count, a_out_pc} !== {2'd1, 32'h7A0}) begin n_fail++; $display("[TB] FAIL flush_then_accept: got count %0d pc %h expected 1 000007a0", a_count, a_out_pc); end
  endtask

  task automatic test_wrap();
    exp_t e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_entry(op_reg, 3'd0, 32'h800 + 32'(4 * i), 32'(i));
      in_valid = 1'b1;
      sb_q.push_back(cur_exp());
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_entry(op_imm, 3'd0, 32'h900 + 32'(8 * i), 32'(i * 7 + 100));
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++; if ({b_in_ready, b_out_valid} !== 2'b11) begin n_fail++; $display("[TB] FAIL wrap_handshake[%0d]: got %b expected 11", i, {b_in_ready, b_out_valid}); end
      e = sb_q.pop_front();
      n_checks++; if ({b_out_pc, b_out_ctrl, b_out_alu_res, b_out_wdata, b_out_regs, b_out_br_en} !== e) begin n_fail++; $display("[TB] FAIL wrap_order[%0d]: got pc %h expected pc %h", i, b_out_pc, e.pc); end
      sb_q.push_back(cur_exp());
      @(posedge clk); #1;
      n_checks++; if (b_count !== 2'd2) begin n_fail++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected 2", i, b_count); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++; if (b_out_valid !== 1'b1 || b_out_pc !== e.pc || b_out_alu_res !== e.alu) begin n_fail++; $display("[TB] FAIL wrap_drain[%0d]: got valid %b pc %h expected valid 1 pc %h", k, b_out_valid, b_out_pc, e.pc); end
      @(posedge clk); #1;
    end
    n_checks++; if ({b_count, b_out_valid} !== 3'b000) begin n_fail++; $display("[TB] FAIL wrap_empty: got %b expected 000", {b_count, b_out_valid}); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_entry(op_store, sh, 32'hA00 + 32'(4 * i), 32'h0000_0042);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (a_count !== 2'd2) begin n_fail++; $display("[TB] FAIL arst_prefill: got %0d expected 2", a_count); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({a_count, a_out_valid, a_in_ready} !== 4'b0001) begin n_fail++; $display("[TB] FAIL arst_state: got %b expected 0001", {a_count, a_out_valid, a_in_ready}); end
    n_checks++; if ({a_out_pc, a_out_alu_res, a_out_wmask, a_out_shift} !== '0) begin n_fail++; $display("[TB] FAIL arst_outputs: got pc %h alu %h wmask %b expected zero", a_out_pc, a_out_alu_res, a_out_wmask); end
    rst = 1'b0;
    set_entry(op_reg, 3'd0, 32'h900D, 32'h55);
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_no_comb_path: got %b expected 0", a_out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if ({a_out_valid, a_count, a_out_pc} !== {1'b1, 2'd1, 32'h900D}) begin n_fail++; $display("[TB] FAIL arst_accept: got valid %b count %0d pc %h expected 1 1 0000900d", a_out_valid, a_count, a_out_pc); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_sb_align();
    test_back_to_back();
    test_misalign();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_fifo.md
MEM_STAGE_FIFO -- requirements
Module: mem_stage_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered EX->MEM entries (legal range 1..8).
REQ-002 SHALL have parameter MISALIGN_TRAP, default 1, where 1 enables the misaligned-access trap.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have these ports:
- flush  in  1  sync kill of all entries.
- in_valid  in  1  EX offers an entry.
- in_ready  out  1  buffer accepts the entry.
- in_pc  in  32  EX pc.
- in_ctrl  in  rv32i_control_word  EX control.
- in_regs  in  rv32i_reg_word  EX register fields.
- in_br_en  in  1  branch taken.
- in_alu_res  in  32  address or result.
- in_wdata  in  32  store data.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM consumes head.
- out_pc, out_ctrl, out_regs, out_br_en, out_alu_res, out_wdata  out  -  head copies of the inputs.
- out_addr_aligned  out  32  {alu_res[31:2],2'b00}.
- out_shift  out  2  alu_res[1:0].
- out_wmask  out  4  store byte enable.
- out_rmask  out  4  load byte mask.
- out_trap  out  1  trap flag.
- count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-005 SHALL accept an entry on a rising edge with in_valid=1, in_ready=1 and flush=0.
REQ-006 SHALL drive in_ready = (count<DEPTH) | out_ready, combinationally.
REQ-007 SHALL consume the head on a rising edge with out_valid=1, out_ready=1 and flush=0.
REQ-008 SHALL drive out_valid = (count!=0).
REQ-009 SHALL present an accepted entry at the outputs no earlier than 1 cycle after acceptance; there is no combinational in->out path.
REQ-010 SHALL keep count unchanged when enqueue and dequeue occur on the same edge, including at count==DEPTH and count==1.
REQ-011 SHALL wrap the read and write pointers from DEPTH-1 to 0, including for non-power-of-2 DEPTH.
REQ-012 SHALL, on flush=1, set count to 0 and both pointers to 0 on that edge; flush wins over a simultaneous enqueue or dequeue.
REQ-013 SHALL compute the masks and trap from in_ctrl and in_alu_res[1:0] at enqueue and store them with the entry:
- sw: wmask 1111.
- sh: wmask 0011<<a.
- sb: wmask 0001<<a.
- lw: rmask 1111.
- lh/lhu: rmask 0011<<a.
- lb/lbu: rmask 0001<<a.
- All other opcodes: both masks 0000.
REQ-014 SHALL set trap for any undefined opcode, or for an undefined funct3 under op_br, op_load or op_store.
REQ-015 SHALL, when MISALIGN_TRAP=1, also set trap for lw/sw with a!=00 and for lh/lhu/sh with a[0]=1.
REQ-016 SHALL force wmask and rmask to 0000 whenever trap=1.
REQ-017 SHALL drive every out_* data field to zero while out_valid=0.
REQ-018 SHALL leave storage unchanged when no enqueue occurs; no entry is ever overwritten while occupied.

Reset
REQ-019 SHALL, while rst=1 (asynchronously), force count, pointers, out_valid and every out_* to 0; in_ready then equals 1 for DEPTH>=1.
REQ-020 SHALL discard any in-flight entries on reset mid-operation; the first accept after reset lands in slot 0.

Structure
REQ-021 SHALL define the typedef mem_stage_entry_t (pc, ctrl, regs, br_en, alu_res, wdata, wmask, rmask, trap) in rv32i_types.
REQ-022 SHALL place the mask/trap logic in the combinational sub-module mem_mask_gen, instantiated once on the enqueue path.

Verification
REQ-023 SHALL verify: after reset, in_valid=1 with sb, alu_res=0x1003, out_ready=0 -> next cycle out_valid=1, out_wmask=1000, out_addr_aligned=0x1000, out_shift=3, count=1.
REQ-024 SHALL verify: DEPTH=2, out_ready=0, three offers -> first two accepted, in_ready=0 at count=2; then out_ready=1 with in_valid=1 -> count stays 2 and FIFO order is preserved.
REQ-025 SHALL verify: lw at 0x2002 with MISALIGN_TRAP=1 -> out_trap=1, rmask=0000; with MISALIGN_TRAP=0 -> out_trap=0, rmask=1111.
REQ-026 SHALL verify: flush asserted together with in_valid=1 at count=2 -> next cycle count=0, out_valid=0, all out_* zero.
REQ-027 SHALL verify: DEPTH=3, seven enqueue/dequeue pairs -> pointer wrap, outputs equal the inputs in order, and no loss.
REQ-028 SHALL verify: rst pulsed asynchronously between edges with count=2 -> outputs are zero immediately, and a following accept appears after 1 cycle.
